// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port ids, transfer sizes.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {PORT_IF, PORT_D} port_t;

  localparam logic [3:0] XFER_BYTE  = 4'd1;
  localparam logic [3:0] XFER_DWORD = 4'd8;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the unified-memory arbiter.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [3:0]        d_size;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_size;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;

  // slave: the arbiter; master: fetch unit, datapath and memory macro around it
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rvalid, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size, err
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rvalid, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_size, err
  );
endinterface

// File: rtl/unified_mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: on conflict the port that did not win last goes first.
module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic  req_if_i,
  input  logic  req_d_i,
  input  port_t last_gnt_i,
  output logic  vld_o,
  output port_t owner_o
);
  always_comb begin
    vld_o   = req_if_i | req_d_i;
    owner_o = PORT_IF;
    if (req_if_i && req_d_i) owner_o = (last_gnt_i == PORT_D) ? PORT_IF : PORT_D;
    else if (req_d_i)        owner_o = PORT_D;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory shared by fetch and data ports; one transaction at a time,
// round-robin on conflict, bounded wait for the memory response.
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int WAIT_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  arb_state_t        state_q, state_d;
  port_t             last_gnt_q, last_gnt_d, owner_q, owner_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_done_q, if_done_d, d_done_q, d_done_d, err_q, err_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_size_q, mem_size_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0] resp_data;
  logic              pick_vld;
  port_t             pick_owner;

  rr_pick2 u_pick (
    .req_if_i   (bus.if_req),
    .req_d_i    (bus.d_req),
    .last_gnt_i (last_gnt_q),
    .vld_o      (pick_vld),
    .owner_o    (pick_owner)
  );

  // A response arriving on the final wait cycle still counts as a real response
  assign resp_data = bus.mem_rvalid ? bus.mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d   = ISSUE;
        owner_d   = pick_owner;
        mem_req_d = 1'b1;
        if (pick_owner == PORT_IF) begin
          if_gnt_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
          mem_size_d  = XFER_DWORD;
        end else begin
          d_gnt_d     = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          mem_size_d  = bus.d_size;
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = '0;
      end
      WAIT: if (bus.mem_rvalid || wait_cnt_q == WaitMax) begin
        state_d    = RESP;
        last_gnt_d = owner_q;
        err_d      = ~bus.mem_rvalid;
        if (owner_q == PORT_IF) begin
          if_done_d  = 1'b1;
          if_rdata_d = resp_data;
        end else begin
          d_done_d  = 1'b1;
          d_rdata_d = resp_data;
        end
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_D;
      owner_q     <= PORT_IF;
      wait_cnt_q  <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset abort, lone fetch, conflict order, store,
// timeout, rvalid on the last wait cycle, spurious rvalid and byte load.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .WAIT_MAX(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {if_gnt, d_gnt, if_done, d_done, err, mem_req}
  function automatic logic [5:0] pulses();
    return {bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done, bus.err, bus.mem_req};
  endfunction

  task automatic ack(input logic [63:0] data);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    int lat;
    bit seen;
    logic [63:0] exp_data;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_size = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // ---- 1: reset state, then reset in the middle of WAIT ----
    tick(); tick();
    chk("rst_pulses", 64'(pulses()), 64'h0);
    chk("rst_outs", {63'h0, bus.mem_we} | bus.mem_addr | bus.mem_wdata | 64'(bus.mem_size)
        | bus.if_rdata | bus.d_rdata, 64'h0);
    reset = 1'b0;
    bus.if_req = 1; bus.if_addr = 64'h100;
    tick();
    chk("pre_rst_gnt", 64'(pulses()), 64'b100001);
    tick(); tick();
    reset = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_pulses", 64'(pulses()), 64'h0);
    end
    chk("midrst_addr", bus.mem_addr, 64'h0);
    reset = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 0;
    chk("post_rst_idle", 64'(pulses()), 64'h0);
    tick();
    chk("post_rst_gnt", 64'(pulses()), 64'b100001);
    chk("post_rst_addr", bus.mem_addr, 64'h100);
    tick();
    ack(64'hAAAA5555);
    chk("post_rst_done", 64'(pulses()), 64'b001000);
    chk("post_rst_rdata", bus.if_rdata, 64'hAAAA5555);
    bus.if_req = 0;
    tick();

    // ---- 2: lone fetch, two empty wait cycles before the response ----
    bus.if_req = 1; bus.if_addr = 64'h40;
    tick();
    chk("f_gnt", 64'(pulses()), 64'b100001);
    chk("f_addr", bus.mem_addr, 64'h40);
    chk("f_we", 64'(bus.mem_we), 64'h0);
    tick();
    chk("f_gnt_once", 64'(pulses()), 64'h0);
    tick(); tick();
    ack(64'h14000000);
    chk("f_done", 64'(pulses()), 64'b001000);
    chk("f_rdata", 64'(bus.if_rdata[31:0]), 64'h14000000);
    bus.if_req = 0;
    tick();
    chk("f_done_once", 64'(pulses()), 64'h0);
    chk("f_addr_hold", bus.mem_addr, 64'h40);

    // ---- 3: conflict from reset: IF, D, IF, D ----
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.if_req = 1; bus.if_addr = 64'h200;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h300; bus.d_size = 4'd8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cf_gnt", 64'(pulses()), (i % 2 == 0) ? 64'b100001 : 64'b010001);
      chk("cf_addr", bus.mem_addr, (i % 2 == 0) ? 64'h200 : 64'h300);
      tick();
      chk("cf_gnt_once", 64'(pulses()), 64'h0);
      ack(64'h1000 + 64'(i));
      chk("cf_done", 64'(pulses()), (i % 2 == 0) ? 64'b001000 : 64'b000100);
      tick();
    end
    chk("cf_if_rdata", bus.if_rdata, 64'h1002);
    chk("cf_d_rdata", bus.d_rdata, 64'h1003);
    bus.if_req = 0; bus.d_req = 0;
    tick();

    // ---- 4: doubleword store ----
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h8; bus.d_wdata = 64'hDEADBEEF; bus.d_size = 4'd8;
    tick();
    chk("st_gnt", 64'(pulses()), 64'b010001);
    chk("st_we", 64'(bus.mem_we), 64'h1);
    chk("st_size", 64'(bus.mem_size), 64'h8);
    chk("st_addr", bus.mem_addr, 64'h8);
    chk("st_wdata", bus.mem_wdata, 64'hDEADBEEF);
    tick();
    ack(64'h1234);
    chk("st_done", 64'(pulses()), 64'b000100);
    bus.d_req = 0; bus.d_we = 0;
    tick();

    // ---- 5: timeout, memory never answers ----
    bus.d_req = 1; bus.d_addr = 64'h10;
    tick();
    chk("to_gnt", 64'(pulses()), 64'b010001);
    lat = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (bus.d_done || bus.err) begin
        seen = 1; lat = i;
      end
    end
    chk("to_latency", 64'(lat), 64'd17);
    chk("to_done_err", 64'(pulses()), 64'b000110);
    chk("to_rdata", bus.d_rdata, 64'h0);
    bus.d_req = 0;
    tick();
    chk("to_idle", 64'(pulses()), 64'h0);
    tick();
    chk("to_no_regnt", 64'(pulses()), 64'h0);

    // ---- rvalid on the very last wait cycle is a real response ----
    bus.d_req = 1; bus.d_addr = 64'h18;
    tick();
    chk("edge_gnt", 64'(pulses()), 64'b010001);
    repeat (16) tick();
    exp_data = 64'hCAFEF00D;
    ack(exp_data);
    chk("edge_done_noerr", 64'(pulses()), 64'b000100);
    chk("edge_rdata", bus.d_rdata, exp_data);
    bus.d_req = 0;
    tick();

    // ---- 6: spurious rvalid in IDLE, then byte load ----
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hFFFF;
    tick();
    chk("spur1", 64'(pulses()), 64'h0);
    tick();
    chk("spur2", 64'(pulses()), 64'h0);
    chk("spur_rdata", bus.d_rdata, 64'hCAFEF00D);
    bus.mem_rvalid = 0; bus.mem_rdata = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h13; bus.d_size = 4'd1;
    tick();
    chk("lb_gnt", 64'(pulses()), 64'b010001);
    chk("lb_size", 64'(bus.mem_size), 64'h1);
    chk("lb_addr", bus.mem_addr, 64'h13);
    chk("lb_we", 64'(bus.mem_we), 64'h0);
    tick();
    ack(64'h0123456789ABCDEF);
    chk("lb_done", 64'(pulses()), 64'b000100);
    chk("lb_rdata", bus.d_rdata, 64'h0123456789ABCDEF);
    chk("lb_if_hold", bus.if_rdata, 64'h1002);
    bus.d_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
